// File: rtl/end_fade_ctrl_if.sv
// Pixel/palette bus of the end-screen fader.
// The master side is the VGA pipeline plus palette ROM; the slave side is the fader.
interface end_fade_ctrl_if;
    logic       pix_valid;
    logic [2:0] pix_index;
    logic [2:0] pal_index;
    logic [3:0] pal_red;
    logic [3:0] pal_green;
    logic [3:0] pal_blue;
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
    logic       out_valid;

    modport master (
        output pix_valid, pix_index, pal_red, pal_green, pal_blue,
        input  pal_index, red, green, blue, out_valid
    );

    modport slave (
        input  pix_valid, pix_index, pal_red, pal_green, pal_blue,
        output pal_index, red, green, blue, out_valid
    );
endinterface

// File: rtl/end_fade_ctrl.sv
// End-screen fade controller: ramps brightness 0->16 over vsync ticks, holds,
// ramps back to 0, then pulses done. Pixels are scaled by the current level
// with a single register stage.
module end_fade_ctrl #(
    parameter int unsigned FRAMES_PER_STEP = 4,
    parameter int unsigned HOLD_FRAMES     = 120
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic                vsync,
    end_fade_ctrl_if.slave      pix,
    output logic [4:0]          level,
    output logic                busy,
    output logic                done
);

    typedef enum logic [2:0] {
        StIdle,
        StFadeIn,
        StHold,
        StFadeOut,
        StDone
    } state_e;

    localparam logic [9:0] StepLast = 10'(FRAMES_PER_STEP - 1);
    localparam logic [9:0] HoldLast = 10'(HOLD_FRAMES - 1);

    state_e     state;
    logic       vsync_q;
    logic [9:0] frame_cnt;
    logic       tick;
    logic [8:0] prod_r;
    logic [8:0] prod_g;
    logic [8:0] prod_b;

    // One tick per vsync rising edge, however long vsync stays high.
    assign tick = vsync & ~vsync_q;

    // Palette lookup is combinational in the ROM, so the index passes straight through.
    assign pix.pal_index = pix.pix_index;

    // Level-scaled channels; level 16 reproduces the channel exactly after >> 4.
    always_comb begin
        prod_r = 9'(pix.pal_red) * 9'(level);
        prod_g = 9'(pix.pal_green) * 9'(level);
        prod_b = 9'(pix.pal_blue) * 9'(level);
    end

    // Registered copy of vsync for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_q <= 1'b0;
        end else begin
            vsync_q <= vsync;
        end
    end

    // Sequence FSM; level, busy and done are registered alongside the state.
    // The frame counter is cleared on every transition, so a tick on the
    // transition edge is consumed by the old state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            level     <= 5'd0;
            frame_cnt <= 10'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    level <= 5'd0;
                    if (start) begin
                        state     <= StFadeIn;
                        frame_cnt <= 10'd0;
                        busy      <= 1'b1;
                    end
                end
                StFadeIn: begin
                    if (abort) begin
                        state     <= StDone;
                        level     <= 5'd0;
                        frame_cnt <= 10'd0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else if (tick) begin
                        if (frame_cnt == StepLast) begin
                            frame_cnt <= 10'd0;
                            level     <= level + 5'd1;
                            if (level == 5'd15) begin
                                state <= StHold;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + 10'd1;
                        end
                    end
                end
                StHold: begin
                    if (abort) begin
                        state     <= StDone;
                        level     <= 5'd0;
                        frame_cnt <= 10'd0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else if (tick) begin
                        if (frame_cnt == HoldLast) begin
                            state     <= StFadeOut;
                            frame_cnt <= 10'd0;
                        end else begin
                            frame_cnt <= frame_cnt + 10'd1;
                        end
                    end
                end
                StFadeOut: begin
                    if (abort) begin
                        state     <= StDone;
                        level     <= 5'd0;
                        frame_cnt <= 10'd0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else if (tick) begin
                        if (frame_cnt == StepLast) begin
                            frame_cnt <= 10'd0;
                            level     <= level - 5'd1;
                            if (level == 5'd1) begin
                                state <= StDone;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + 10'd1;
                        end
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state     <= StIdle;
                    level     <= 5'd0;
                    frame_cnt <= 10'd0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // One-stage pixel pipeline; colour is forced to 0 when the slot is empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix.out_valid <= 1'b0;
            pix.red       <= 4'd0;
            pix.green     <= 4'd0;
            pix.blue      <= 4'd0;
        end else begin
            pix.out_valid <= pix.pix_valid;
            if (pix.pix_valid) begin
                pix.red   <= 4'(prod_r >> 4);
                pix.green <= 4'(prod_g >> 4);
                pix.blue  <= 4'(prod_b >> 4);
            end else begin
                pix.red   <= 4'd0;
                pix.green <= 4'd0;
                pix.blue  <= 4'd0;
            end
        end
    end

endmodule
